// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: holds HI/LO, models fixed mult/div latency with a countdown.
// Optional exception-flush input `abort` is present when MDU_ABORT_EN is defined.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MDU_ABORT_EN
  input  logic        abort,
`endif
  output logic        busy,
  output logic        md_busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic          abort_s;

  logic [63:0]   mul_s_s, mul_u_s;
  logic [31:0]   a_mag_s, b_mag_s, sq_mag_s, sr_mag_s;
  logic [31:0]   div_s_q_s, div_s_r_s, div_u_q_s, div_u_r_s;

`ifdef MDU_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Arithmetic results for the operands presented this cycle
  always_comb begin
    mul_s_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    mul_u_s = {32'd0, a} * {32'd0, b};
    a_mag_s = a[31] ? (32'd0 - a) : a;
    b_mag_s = b[31] ? (32'd0 - b) : b;
    if (b == 32'd0) begin
      sq_mag_s  = 32'd0;
      sr_mag_s  = 32'd0;
      div_u_q_s = 32'd0;
      div_u_r_s = 32'd0;
    end else begin
      sq_mag_s  = a_mag_s / b_mag_s;
      sr_mag_s  = a_mag_s % b_mag_s;
      div_u_q_s = a / b;
      div_u_r_s = a % b;
    end
    // Magnitude division then sign fix-up; 0x80000000 / -1 wraps to 0x80000000 naturally.
    div_s_q_s = (a[31] ^ b[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
    div_s_r_s = a[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
  end

  // Next-state: launch, countdown, commit and optional flush
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    if (abort_s) begin
      state_d = S_IDLE;
      cnt_d   = {CW{1'b0}};
      hi_n_d  = 32'd0;
      lo_n_d  = 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                {hi_n_d, lo_n_d} = mul_s_s;
                cnt_d            = MULT_LOAD;
                state_d          = S_RUN;
              end
              OP_MULTU: begin
                {hi_n_d, lo_n_d} = mul_u_s;
                cnt_d            = MULT_LOAD;
                state_d          = S_RUN;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero commits the current HI/LO, which cannot change while busy.
                if (b == 32'd0) begin
                  hi_n_d = hi_q;
                  lo_n_d = lo_q;
                end else if (op == OP_DIV) begin
                  hi_n_d = div_s_r_s;
                  lo_n_d = div_s_q_s;
                end else begin
                  hi_n_d = div_u_r_s;
                  lo_n_d = div_u_q_s;
                end
                cnt_d   = DIV_LOAD;
                state_d = S_RUN;
              end
              OP_MTHI: hi_d = a;
              OP_MTLO: lo_d = a;
              default: state_d = S_IDLE;
            endcase
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (cnt_q == CW'(1)) begin
            hi_d    = hi_n_q;
            lo_d    = lo_n_q;
            done_d  = 1'b1;
            cnt_d   = {CW{1'b0}};
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end
    busy_d = (state_d == S_RUN);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_n_q  <= 32'd0;
      lo_n_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign md_busy = busy_q | (start & (op <= OP_DIVU));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios plus random traffic checked each cycle
// against a transaction-level model (commit scheduled at an absolute edge number).
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_ABORT_EN
  localparam bit HAS_ABORT = 1'b1;
`else
  localparam bit HAS_ABORT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, md_busy, done;
  logic [31:0] hi, lo;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
`ifdef MDU_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .md_busy(md_busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  bit          m_pend = 1'b0, m_done = 1'b0;
  int          edge_n = 0, commit_at = 0;
  int          busy_seen = 0, done_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit st, input logic [2:0] o,
                            input logic [31:0] av, input logic [31:0] bv, input bit ab);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uprod;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    if (rst) begin
      m_hi = 32'd0; m_lo = 32'd0; m_pend = 1'b0; m_done = 1'b0;
    end else if (ab) begin
      m_pend = 1'b0; m_done = 1'b0;
    end else if (m_pend && edge_n == commit_at) begin
      m_hi = m_phi; m_lo = m_plo; m_pend = 1'b0; m_done = 1'b1;
    end else begin
      m_done = 1'b0;
      if (!m_pend && st) begin
        case (o)
          3'd0: begin
            sq = sa * sb;
            {m_phi, m_plo} = sq;
            m_pend = 1'b1; commit_at = edge_n + MC;
          end
          3'd1: begin
            uprod = ua * ub;
            {m_phi, m_plo} = uprod;
            m_pend = 1'b1; commit_at = edge_n + MC;
          end
          3'd2, 3'd3: begin
            if (bv == 32'd0) begin
              m_phi = m_hi; m_plo = m_lo;
            end else if (o == 3'd2) begin
              sq = sa / sb; sr = sa % sb;
              m_plo = sq[31:0]; m_phi = sr[31:0];
            end else begin
              uprod = ua / ub; m_plo = uprod[31:0];
              uprod = ua % ub; m_phi = uprod[31:0];
            end
            m_pend = 1'b1; commit_at = edge_n + DC;
          end
          3'd4: m_hi = av;
          3'd5: m_lo = av;
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input bit rst, input bit st, input logic [2:0] o,
                      input logic [31:0] av, input logic [31:0] bv, input bit ab_in);
    bit ab;
    ab = ab_in & HAS_ABORT;
    reset = rst; start = st; op = o; a = av; b = bv; abort = ab;
    #1;
    if (!rst) check_eq("md_busy", md_busy, m_pend | (st && o <= 3'd3));
    @(posedge clk);
    edge_n++;
    model_edge(rst, st, o, av, bv, ab);
    #1;
    check_eq("busy", busy, m_pend);
    check_eq("done", done, m_done);
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
    busy_seen += int'(busy);
    done_seen += int'(done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0: rand_word = 32'd0;
      1: rand_word = 32'hFFFF_FFFF;
      2: rand_word = 32'h8000_0000;
      3: rand_word = 32'($urandom_range(0, 20));
      default: rand_word = $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; abort = 1'b0;
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);

    busy_seen = 0; done_seen = 0;
    step(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    idle(8);
    check_eq("mult_busy_len", busy_seen, 5);
    check_eq("mult_done_cnt", done_seen, 1);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFEB);

    busy_seen = 0; done_seen = 0;
    step(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    check_eq("multu_old_lo", lo, 32'hFFFF_FFEB);
    idle(8);
    check_eq("multu_busy_len", busy_seen, 5);
    check_eq("multu_hi", hi, 32'd1);
    check_eq("multu_lo", lo, 32'hFFFF_FFFE);

    busy_seen = 0; done_seen = 0;
    step(1'b0, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(12);
    check_eq("div_busy_len", busy_seen, 10);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);

    busy_seen = 0; done_seen = 0;
    step(1'b0, 1'b1, 3'd3, 32'd7, 32'd0, 1'b0);
    idle(12);
    check_eq("divz_busy_len", busy_seen, 10);
    check_eq("divz_done_cnt", done_seen, 1);
    check_eq("divz_hi", hi, 32'hFFFF_FFFF);
    check_eq("divz_lo", lo, 32'hFFFF_FFFD);

    busy_seen = 0;
    step(1'b0, 1'b1, 3'd4, 32'h0000_1234, 32'd0, 1'b0);
    check_eq("mthi_hi", hi, 32'h0000_1234);
    check_eq("mthi_busy", busy, 1'b0);
    step(1'b0, 1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
    step(1'b0, 1'b1, 3'd5, 32'h0000_DEAD, 32'd0, 1'b0);
    idle(8);
    check_eq("mtlo_busy_lo", lo, 32'd6);
    check_eq("mtlo_busy_hi", hi, 32'd0);

    step(1'b0, 1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    check_eq("rstmid_busy", busy, 1'b0);
    check_eq("rstmid_hi", hi, 32'd0);
    check_eq("rstmid_lo", lo, 32'd0);
    done_seen = 0;
    idle(12);
    check_eq("rstmid_no_done", done_seen, 0);

    if (HAS_ABORT) begin
      step(1'b0, 1'b1, 3'd4, 32'd5, 32'd0, 1'b0);
      step(1'b0, 1'b1, 3'd5, 32'd5, 32'd0, 1'b0);
      step(1'b0, 1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
      idle(1);
      done_seen = 0;
      step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      check_eq("abort_busy", busy, 1'b0);
      idle(8);
      check_eq("abort_no_done", done_seen, 0);
      check_eq("abort_hi", hi, 32'd5);
      check_eq("abort_lo", lo, 32'd5);
    end

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
           rand_word(), rand_word(), $urandom_range(0, 39) == 0);
    end
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
